acm_rp_scrubber: RTL and testbench

- Parametrised read-port address scrubber for the ID stage.
- Whenever a register-file read port is idle, it places a sweeping scrub address on that port's IDOP read-address register. The OP stage then proactively reads and checks every register-file entry.
- Generalises the earlier fixed two-port scheme to RP ports, a configurable address window, and multi-port allocation: several idle ports in one cycle receive consecutive addresses.
- Adds starvation-driven restart requests and a completed-sweep counter.

---
 rtl/acm_rp_scrubber.sv | 112 +++++++++++
 tb/tb_acm_rp_scrubber.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/acm_rp_scrubber.sv
// Read-port address scrubber for the ID stage: idle register-file read ports are
// handed consecutive addresses from a sweeping window so the OP stage can check every entry.

module acm_rp_scrubber_lane #(
  parameter int AW       = 5,
  parameter int ADDR_MIN = 1,
  parameter int ADDR_MAX = 31
) (
  input  logic          sel,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   rank,
  output logic [AW-1:0] padd
);
  localparam logic [AW:0] MAXV = (AW+1)'(ADDR_MAX);
  localparam logic [AW:0] RNG  = (AW+1)'(ADDR_MAX - ADDR_MIN + 1);

  logic [AW:0] sum;

  always_comb begin
    sum  = {1'b0, base} + rank;
    padd = base;
    if (sel) padd = AW'((sum > MAXV) ? sum - RNG : sum);
  end
endmodule

module acm_rp_scrubber #(
  parameter int RP       = 2,
  parameter int AW       = 5,
  parameter int ADDR_MIN = 1,
  parameter int ADDR_MAX = 31,
  parameter int SW       = 4
) (
  input  logic             s_clk_i,
  input  logic             s_resetn_i,
  input  logic [1:0]       s_mode_i,
  input  logic             s_stall_i,
  input  logic             s_flush_i,
  input  logic             s_nop_i,
  input  logic [RP-1:0]    s_id_free_i,
  input  logic [RP-1:0]    s_op_free_i,
  output logic [RP-1:0]    s_scrub_o,
  output logic [RP*AW-1:0] s_padd_o,
  output logic             s_restart_o,
  output logic [7:0]       s_passes_o,
  output logic [SW-1:0]    s_starve_o
);
  localparam logic [AW:0] MAXV = (AW+1)'(ADDR_MAX);
  localparam logic [AW:0] RNG  = (AW+1)'(ADDR_MAX - ADDR_MIN + 1);

  logic [AW-1:0]          a;
  logic [SW-1:0]          c;
  logic [7:0]             p;
  logic                   en, starve_mode, restart, wrap;
  logic [RP-1:0]          free;
  logic [RP:0][AW:0]      rank;
  logic [AW:0]            sum_n;
  logic [RP-1:0][AW-1:0]  padd;

  assign en          = s_mode_i[1];
  assign starve_mode = (s_mode_i == 2'b11);
  assign restart     = (c == '1) && starve_mode;

  // Flush beats stall; a nop slot leaves every port idle.
  always_comb begin
    free = '0;
    if (en) begin
      if (s_flush_i)      free = '1;
      else if (s_stall_i) free = s_op_free_i;
      else if (s_nop_i)   free = '1;
      else                free = s_id_free_i;
    end
  end

  // rank[k] = number of free ports below k; rank[RP] is the total advance.
  always_comb begin
    rank[0] = '0;
    for (int k = 0; k < RP; k++) rank[k+1] = rank[k] + {{AW{1'b0}}, free[k]};
  end

  assign sum_n = {1'b0, a} + rank[RP];
  assign wrap  = (sum_n > MAXV);

  for (genvar k = 0; k < RP; k++) begin : g_lane
    acm_rp_scrubber_lane #(.AW(AW), .ADDR_MIN(ADDR_MIN), .ADDR_MAX(ADDR_MAX)) u_lane (
      .sel  (free[k]),
      .base (a),
      .rank (rank[k]),
      .padd (padd[k])
    );
  end

  always_ff @(posedge s_clk_i) begin
    if (!s_resetn_i) begin
      a <= AW'(ADDR_MIN);
      c <= '0;
      p <= '0;
    end else begin
      if (en) begin
        a <= AW'(wrap ? sum_n - RNG : sum_n);
        if (wrap && p != 8'hff) p <= p + 8'd1;
      end
      if (!starve_mode || restart || rank[RP] != '0) c <= '0;
      else                                           c <= c + SW'(1);
    end
  end

  assign s_scrub_o   = free;
  assign s_padd_o    = padd;
  assign s_restart_o = restart;
  assign s_passes_o  = p;
  assign s_starve_o  = c;
endmodule

// File: tb/tb_acm_rp_scrubber.sv
// Directed scoreboard bench for acm_rp_scrubber (RP=2, AW=5, window 1..31, SW=4).

module tb_acm_rp_scrubber;
  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] mode;
  logic       stall, flush, nop;
  logic [1:0] idf, opf;
  logic [1:0] scrub;
  logic [9:0] padd;
  logic       restart;
  logic [7:0] passes;
  logic [3:0] starve;

  typedef struct {
    logic [1:0] scrub;
    logic [4:0] p0, p1;
    logic       rst;
    logic [7:0] npass;
    logic [3:0] starve;
    string      name;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  acm_rp_scrubber dut (
    .s_clk_i     (clk),
    .s_resetn_i  (resetn),
    .s_mode_i    (mode),
    .s_stall_i   (stall),
    .s_flush_i   (flush),
    .s_nop_i     (nop),
    .s_id_free_i (idf),
    .s_op_free_i (opf),
    .s_scrub_o   (scrub),
    .s_padd_o    (padd),
    .s_restart_o (restart),
    .s_passes_o  (passes),
    .s_starve_o  (starve)
  );

  always #5 clk = ~clk;

  // Monitor: compares outputs mid-cycle against the oldest pending expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      if ({scrub, padd[4:0], padd[9:5], restart, passes, starve} ==
          {e.scrub, e.p0, e.p1, e.rst, e.npass, e.starve})
        passed++;
      else
        $display("FAIL %s: got scrub=%b p0=%0d p1=%0d restart=%b passes=%0d starve=%0d, expected scrub=%b p0=%0d p1=%0d restart=%b passes=%0d starve=%0d",
                 e.name, scrub, padd[4:0], padd[9:5], restart, passes, starve,
                 e.scrub, e.p0, e.p1, e.rst, e.npass, e.starve);
    end
  end

  task automatic apply(input logic rn, input logic [1:0] m, input logic st, input logic fl,
                       input logic np, input logic [1:0] i_f, input logic [1:0] o_f);
    resetn = rn; mode = m; stall = st; flush = fl; nop = np; idf = i_f; opf = o_f;
  endtask

  task automatic idle(input int n, input logic rn, input logic [1:0] m, input logic st,
                      input logic fl, input logic np, input logic [1:0] i_f, input logic [1:0] o_f);
    repeat (n) begin
      apply(rn, m, st, fl, np, i_f, o_f);
      @(posedge clk); #1;
    end
  endtask

  task automatic step(input logic rn, input logic [1:0] m, input logic st, input logic fl,
                      input logic np, input logic [1:0] i_f, input logic [1:0] o_f,
                      input logic [1:0] es, input logic [4:0] e0, input logic [4:0] e1,
                      input logic er, input logic [7:0] ep, input logic [3:0] ec, input string nm);
    exp_t e;
    apply(rn, m, st, fl, np, i_f, o_f);
    e.scrub = es; e.p0 = e0; e.p1 = e1; e.rst = er; e.npass = ep; e.starve = ec; e.name = nm;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d checks", passed, total);
    $fatal(1, "watchdog");
  end

  initial begin
    apply(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    repeat (2) @(posedge clk);
    #1;

    // Reset state, both ports busy: nothing scrubbed, A stays 1.
    for (int i = 0; i < 5; i++)
      step(1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd1, 5'd1, 0, 8'd0, 4'd0, "busy_after_reset");

    // Port 0 idle for three cycles.
    step(1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b01, 5'd1, 5'd1, 0, 8'd0, 4'd0, "port0_a1");
    step(1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b01, 5'd2, 5'd2, 0, 8'd0, 4'd0, "port0_a2");
    step(1, 2'b10, 0, 0, 0, 2'b01, 2'b00, 2'b01, 5'd3, 5'd3, 0, 8'd0, 4'd0, "port0_a3");
    step(1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd4, 5'd4, 0, 8'd0, 4'd0, "a_is_4");

    // Walk A from 4 to 30 with nop slots (two addresses per cycle).
    idle(13, 1, 2'b10, 0, 0, 1, 2'b00, 2'b00);
    step(1, 2'b10, 0, 0, 1, 2'b00, 2'b00, 2'b11, 5'd30, 5'd31, 0, 8'd0, 4'd0, "a30_pair");
    step(1, 2'b10, 0, 0, 1, 2'b00, 2'b00, 2'b11, 5'd1,  5'd2,  0, 8'd1, 4'd0, "after_wrap_a1");
    idle(14, 1, 2'b10, 0, 0, 1, 2'b00, 2'b00);
    step(1, 2'b10, 0, 0, 1, 2'b00, 2'b00, 2'b11, 5'd31, 5'd1,  0, 8'd1, 4'd0, "a31_split_wrap");
    step(1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd2,  5'd2,  0, 8'd2, 4'd0, "after_wrap_a2");

    // Stall uses op_free; flush overrides to all ports.
    step(1, 2'b10, 1, 0, 0, 2'b11, 2'b10, 2'b10, 5'd2, 5'd2, 0, 8'd2, 4'd0, "stall_opfree");
    step(1, 2'b10, 1, 1, 0, 2'b11, 2'b10, 2'b11, 5'd3, 5'd4, 0, 8'd2, 4'd0, "flush_beats_stall");
    step(1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd5, 5'd5, 0, 8'd2, 4'd0, "a_is_5");

    // Starvation: 15 idle-less cycles, restart on C=15, then cleared.
    for (int i = 0; i < 16; i++)
      step(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd5, 5'd5, (i == 15), 8'd2, 4'(i), "starve_count");
    step(1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd5, 5'd5, 0, 8'd2, 4'd0, "starve_cleared");

    // Progress at C=9 clears the counter without a restart.
    for (int i = 0; i < 9; i++)
      step(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd5, 5'd5, 0, 8'd2, 4'(i), "starve_partial");
    step(1, 2'b11, 0, 0, 1, 2'b00, 2'b00, 2'b11, 5'd5, 5'd6, 0, 8'd2, 4'd9, "starve_c9_progress");
    step(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd7, 5'd7, 0, 8'd2, 4'd0, "starve_c0_again");

    // Mode off: no scrub, A holds, C clears next cycle; re-enable resumes at A.
    step(1, 2'b00, 0, 0, 1, 2'b11, 2'b11, 2'b00, 5'd7, 5'd7, 0, 8'd2, 4'd1, "off_first");
    step(1, 2'b01, 0, 0, 1, 2'b11, 2'b11, 2'b00, 5'd7, 5'd7, 0, 8'd2, 4'd0, "off_second");
    step(1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd7, 5'd7, 0, 8'd2, 4'd0, "resume_held_a");

    // Mid-sweep reset with A=17, C=6.
    idle(5, 1, 2'b10, 0, 0, 1, 2'b00, 2'b00);
    idle(6, 1, 2'b11, 0, 0, 0, 2'b00, 2'b00);
    step(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd17, 5'd17, 0, 8'd2, 4'd6, "pre_reset_a17_c6");
    step(0, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd17, 5'd17, 0, 8'd2, 4'd7, "reset_cycle");
    step(1, 2'b11, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd1,  5'd1,  0, 8'd0, 4'd0, "post_reset");

    // 4080 cycles of two addresses: 263 wraps saturate P, A ends at 8.
    idle(4080, 1, 2'b10, 0, 0, 1, 2'b00, 2'b00);
    step(1, 2'b10, 0, 0, 0, 2'b00, 2'b00, 2'b00, 5'd8, 5'd8, 0, 8'd255, 4'd0, "passes_saturate");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
